// File: rtl/ball_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_ctrl_if
// Description : Frame-event, ball/paddle position and command signals between
//               the Breakout sequencer and its surrounding datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_ctrl_if;
  logic       frame_tick;
  logic       launch;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle_x;
  logic       brick_hit;
  logic       bricks_clear;
  logic       ball_load;
  logic       ball_step;
  logic       flip_dx;
  logic       flip_dy;
  logic [2:0] state;
  logic [1:0] lives;
  logic       game_over;
  logic       win;

  modport slave (
    input  frame_tick, launch, ball_x, ball_y, paddle_x, brick_hit, bricks_clear,
    output ball_load, ball_step, flip_dx, flip_dy, state, lives, game_over, win
  );

  modport master (
    output frame_tick, launch, ball_x, ball_y, paddle_x, brick_hit, bricks_clear,
    input  ball_load, ball_step, flip_dx, flip_dy, state, lives, game_over, win
  );
endinterface
`default_nettype wire

// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ball_ctrl
// Description : Per-frame Breakout sequencer: game state, lives, and the ball
//               step / direction-flip commands issued once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_W    = 64,
  parameter int LIVES       = 3,
  parameter int SERVE_DELAY = 60
) (
  input  wire logic    clk,
  input  wire logic    reset,
  ball_ctrl_if.slave   bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SERVE = 3'd1;
  localparam logic [2:0] c_PLAY  = 3'd2;
  localparam logic [2:0] c_OVER  = 3'd3;
  localparam logic [2:0] c_WIN   = 3'd4;

  localparam int               c_CNT_W     = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [c_CNT_W-1:0] c_SERVE_CNT = c_CNT_W'(SERVE_DELAY);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [1:0]       c_LIVES     = 2'(LIVES);

  // Geometry thresholds, all in 11 bits so edge sums never wrap
  localparam logic [10:0] c_BS       = 11'(BALL_SIZE);
  localparam logic [10:0] c_X_RIGHT  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] c_Y_MISS   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] c_PADDLE_Y = 11'(PADDLE_Y);
  localparam logic [10:0] c_PADDLE_W = 11'(PADDLE_W);

  logic [2:0]         r_state;
  logic [1:0]         r_lives;
  logic [c_CNT_W-1:0] r_count;
  logic               r_brick;
  logic               r_launch_q;
  logic               r_step;
  logic               r_flip_dx;
  logic               r_flip_dy;

  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic [10:0] w_px;
  logic        w_launch_rise;
  logic        w_miss;
  logic        w_wall_x;
  logic        w_wall_y;
  logic        w_paddle_hit;
  logic        w_brick;

  assign w_bx = {1'b0, bus.ball_x};
  assign w_by = {1'b0, bus.ball_y};
  assign w_px = {1'b0, bus.paddle_x};

  assign w_launch_rise = bus.launch & ~r_launch_q;
  assign w_miss        = (w_by >= c_Y_MISS);
  assign w_wall_x      = (w_bx < c_BS) | (w_bx >= c_X_RIGHT);
  assign w_wall_y      = (w_by < c_BS);
  assign w_paddle_hit  = (w_by + c_BS >= c_PADDLE_Y) & (w_by < c_PADDLE_Y) &
                         (w_bx + c_BS > w_px) & (w_bx < w_px + c_PADDLE_W);
  // A hit arriving in the same cycle as the tick still counts for this frame
  assign w_brick       = r_brick | bus.brick_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_lives    <= c_LIVES;
      r_count    <= '0;
      r_brick    <= 1'b0;
      r_launch_q <= 1'b0;
      r_step     <= 1'b0;
      r_flip_dx  <= 1'b0;
      r_flip_dy  <= 1'b0;
    end else begin
      r_launch_q <= bus.launch;
      r_step     <= 1'b0;
      r_flip_dx  <= 1'b0;
      r_flip_dy  <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (w_launch_rise) begin
            r_state <= c_SERVE;
            r_count <= c_SERVE_CNT;
          end
        end

        c_SERVE: begin
          if (bus.frame_tick) begin
            if (r_count == '0) begin
              r_state <= c_PLAY;
            end else begin
              r_count <= r_count - c_CNT_ONE;
            end
          end
        end

        c_PLAY: begin
          if (bus.frame_tick) begin
            r_brick <= 1'b0;
            if (bus.bricks_clear) begin
              r_state <= c_WIN;
            end else if (w_miss) begin
              if (r_lives == 2'd1) begin
                r_lives <= 2'd0;
                r_state <= c_OVER;
              end else begin
                r_lives <= r_lives - 2'd1;
                r_state <= c_SERVE;
                r_count <= c_SERVE_CNT;
              end
            end else begin
              r_step    <= 1'b1;
              r_flip_dx <= w_wall_x;
              r_flip_dy <= w_wall_y | w_paddle_hit | w_brick;
            end
          end else if (bus.brick_hit) begin
            r_brick <= 1'b1;
          end
        end

        c_OVER, c_WIN: begin
          if (w_launch_rise) begin
            r_state <= c_IDLE;
            r_lives <= c_LIVES;
            r_brick <= 1'b0;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.ball_load = (r_state == c_IDLE) | (r_state == c_SERVE);
  assign bus.ball_step = r_step;
  assign bus.flip_dx   = r_flip_dx;
  assign bus.flip_dy   = r_flip_dy;
  assign bus.state     = r_state;
  assign bus.lives     = r_lives;
  assign bus.game_over = (r_state == c_OVER);
  assign bus.win       = (r_state == c_WIN);

endmodule
`default_nettype wire
